// File: rtl/ram_arbiter_pkg.sv
// Shared types and sizes for the CPU/host RAM arbiter.
// The state encoding is common to both build flavours.
// ST_BOOT is only reachable when the boot-hold feature is compiled in.
package ram_arbiter_pkg;

  localparam int RAM_AW = 4;
  localparam int RAM_DW = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_T0 = 3'd1,
    ST_HOLD    = 3'd2,
    ST_ACCESS  = 3'd3,
    ST_LINGER  = 3'd4,
    ST_BOOT    = 3'd5
  } arb_state_t;

  // True in every state where the host side drives the RAM port
  function automatic logic host_owns(input arb_state_t s);
    return (s == ST_HOLD) || (s == ST_ACCESS) || (s == ST_LINGER) || (s == ST_BOOT);
  endfunction

endpackage

// File: rtl/ram_arbiter_hold_timer.sv
// Linger down-counter: loaded on each host ack, counts toward zero while idle.
// Latency: load/decrement take effect on the next rising edge; zero is combinational.
// No backpressure; decrement saturates at zero.
module ram_arbiter_hold_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load has priority; decrement stops at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates the 16x8 RAM between the CPU (default owner) and a host load/readback port.
// Latency: req->ack 3 edges from IDLE with T0 high, 2 edges for back-to-back requests in LINGER.
// Backpressure: host_req is held until host_ack; CPU is frozen via cpu_hold. Option: RAM_ARB_BOOT_HOLD_EN.
import ram_arbiter_pkg::*;

module ram_arbiter #(
  parameter int LINGER = 4
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              cpu_T0,
  input  logic [RAM_AW-1:0] cpu_addr,
  input  logic [RAM_DW-1:0] cpu_wdata,
  input  logic              cpu_RI,
  output logic [RAM_DW-1:0] cpu_rdata,
  output logic              cpu_hold,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [RAM_AW-1:0] host_addr,
  input  logic [RAM_DW-1:0] host_wdata,
  input  logic              host_run,
  output logic              host_ack,
  output logic [RAM_DW-1:0] host_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [RAM_DW-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [RAM_DW-1:0] ram_rdata
);

  localparam logic [3:0] LINGER_LD = 4'(LINGER);

  arb_state_t        state;
  arb_state_t        home_state;
  logic              home_hold;
  logic              lat_we;
  logic [RAM_AW-1:0] lat_addr;
  logic [RAM_DW-1:0] lat_wdata;
  logic              timer_zero;
  logic              timer_load;
  logic              timer_dec;
  logic              run_rise;

`ifdef RAM_ARB_BOOT_HOLD_EN
  localparam arb_state_t RESET_STATE = ST_BOOT;
  localparam logic       RESET_HOLD  = 1'b1;

  logic run_q;
  logic boot_mode;

  assign run_rise = host_run & ~run_q;

  // Boot mode lasts from reset until the first rising edge of host_run
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      run_q     <= 1'b0;
      boot_mode <= 1'b1;
    end else begin
      run_q <= host_run;
      if (run_rise) boot_mode <= 1'b0;
    end
  end

  assign home_state = (boot_mode && !run_rise) ? ST_BOOT : ST_IDLE;
`else
  localparam arb_state_t RESET_STATE = ST_IDLE;
  localparam logic       RESET_HOLD  = 1'b0;

  logic unused_run;
  assign unused_run = host_run;
  assign run_rise   = 1'b0;
  assign home_state = ST_IDLE;
`endif

  assign home_hold  = (home_state == ST_BOOT);
  assign timer_load = (state == ST_ACCESS);
  assign timer_dec  = (state == ST_LINGER) && !host_req;

  ram_arbiter_hold_timer #(.W(4)) u_hold_timer (
    .clk      (CLK),
    .rst_n    (RESETn),
    .load     (timer_load),
    .dec      (timer_dec),
    .load_val (LINGER_LD),
    .zero     (timer_zero)
  );

  // Ownership FSM; cpu_hold and host_ack are registered alongside the state
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state      <= RESET_STATE;
      cpu_hold   <= RESET_HOLD;
      host_ack   <= 1'b0;
      host_rdata <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      host_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (host_req) begin
            if (cpu_T0) begin
              state    <= ST_HOLD;
              cpu_hold <= 1'b1;
            end else begin
              state <= ST_WAIT_T0;
            end
          end
        end
        ST_WAIT_T0: begin
          if (!host_req) begin
            state <= ST_IDLE;
          end else if (cpu_T0) begin
            state    <= ST_HOLD;
            cpu_hold <= 1'b1;
          end
        end
        ST_HOLD: begin
          lat_we    <= host_we;
          lat_addr  <= host_addr;
          lat_wdata <= host_wdata;
          state     <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (!lat_we) host_rdata <= ram_rdata;
          host_ack <= 1'b1;
          state    <= ST_LINGER;
        end
        ST_LINGER: begin
          if (host_req) begin
            lat_we    <= host_we;
            lat_addr  <= host_addr;
            lat_wdata <= host_wdata;
            state     <= ST_ACCESS;
          end else if (timer_zero) begin
            state    <= home_state;
            cpu_hold <= home_hold;
          end
        end
        ST_BOOT: begin
          if (run_rise) begin
            state    <= ST_IDLE;
            cpu_hold <= 1'b0;
          end else if (host_req) begin
            state <= ST_HOLD;
          end
        end
        default: begin
          state    <= ST_IDLE;
          cpu_hold <= 1'b0;
        end
      endcase
    end
  end

  // RAM port mux: CPU passthrough unless the host side owns the RAM
  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_we    = cpu_RI;
    if (host_owns(state)) begin
      ram_addr  = lat_addr;
      ram_wdata = lat_wdata;
      ram_we    = (state == ST_ACCESS) && lat_we;
    end
    if (!RESETn) ram_we = 1'b0;
  end

  assign cpu_rdata = ram_rdata;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the 16×8 program/data RAM between the CPU datapath and an external host port used for program load and readback. The CPU owns the RAM by default. A host request waits for the CPU to reach an instruction boundary (T0), then freezes the CPU with `cpu_hold` and performs one RAM access per request. The hold lingers briefly so back-to-back loads do not wait for another T0. The block sits between the control unit/MAR/bus and the RAM macro; `cpu_hold` is ORed into the machine's halt path.

## Interface
- `LINGER`, default 4: cycles the hold is kept after an ack while waiting for another host request; legal range 1–15.
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RESETn`  in  1  asynchronous reset, active-low.
- `cpu_T0`  in  1  control-unit step 0 indicator; sampled on the rising edge.
- `cpu_addr`  in  4  MAR contents.
- `cpu_wdata`  in  8  CPU bus value.
- `cpu_RI`  in  1  CPU RAM write strobe, active-high.
- `cpu_rdata`  out  8  RAM read data to the CPU bus.
- `cpu_hold`  out  1  registered; freezes the CPU while high.
- `host_req`  in  1  level-sensitive; high means one access is pending.
- `host_we`  in  1  1 = write, 0 = read.
- `host_addr`  in  4  host RAM address.
- `host_wdata`  in  8  host write data.
- `host_run`  in  1  boot release (see Configuration).
- `host_ack`  out  1  one-cycle pulse marking completion of an access.
- `host_rdata`  out  8  registered read data; valid while `host_ack` is high and held until the next ack.
- `ram_addr`  out  4  RAM address.
- `ram_wdata`  out  8  RAM write data.
- `ram_we`  out  1  RAM write enable.
- `ram_rdata`  in  8  RAM asynchronous read data.

## Operation
- States and transitions:
  - IDLE: CPU owns the RAM. On `host_req`, go to HOLD if `cpu_T0` is high on the same edge, otherwise go to WAIT_T0.
  - WAIT_T0: CPU still owns the RAM. On `cpu_T0`, go to HOLD. If `host_req` falls, go to IDLE with no access.
  - HOLD: `cpu_hold` is 1; one settle cycle. Latch `host_we`, `host_addr` and `host_wdata`, then go to ACCESS.
  - ACCESS: host owns the RAM. `ram_we` equals the latched `we` for exactly this cycle. On the edge leaving the state, capture `ram_rdata` into `host_rdata` for reads, pulse `host_ack`, load the linger counter with `LINGER`, and go to LINGER.
  - LINGER: `cpu_hold` stays 1. If `host_req` is high, re-latch the fields and go directly to ACCESS. Otherwise decrement the counter; at 0, go to IDLE.
- Mux:
  - In IDLE and WAIT_T0, `ram_addr`, `ram_wdata` and `ram_we` pass through `cpu_addr`, `cpu_wdata` and `cpu_RI` combinationally.
  - In HOLD, ACCESS and LINGER, they are driven from the latched host fields; `ram_we` is 0 except in ACCESS.
- `cpu_rdata` = `ram_rdata` always.
- Host fields must be stable from the first `host_req` edge until the ack. To end a session, the host drops `host_req` in the cycle it sees `host_ack`.
- CPU writes during HOLD, ACCESS or LINGER are ignored, because the CPU is frozen.

## Timing
- Reset values:
  - state IDLE (BOOT with the macro)
  - `cpu_hold` 0 (1 with the macro)
  - `host_ack` 0, `host_rdata` 0x00
  - `ram_we` forced 0 while `RESETn` is low
- Latency from `host_req` to `host_ack` with `cpu_T0` high on the same edge: 3 edges.
- Each following back-to-back request in LINGER: 2 edges.
- An asserted `RESETn` aborts any state. A pending access is lost without an ack; a write already in ACCESS completes only if its edge precedes reset.
- `host_req` dropping in HOLD, ACCESS or LINGER does not abort an access already latched.

## Configuration
- `RAM_ARB_BOOT_HOLD_EN` defined:
  - Adds state BOOT, entered on reset, with `cpu_hold` = 1.
  - Host requests are serviced directly from BOOT: BOOT→HOLD, and LINGER returns to BOOT instead of IDLE.
  - A rising `host_run` moves the block to IDLE; `cpu_hold` drops on that edge.
- Undefined: no BOOT state; the CPU runs from reset and `host_run` is ignored.

## Structure
- Shared package: state encoding enum, `RAM_AW`=4, `RAM_DW`=8.
- The linger down-counter is natural as sub-module `hold_timer` (load/decrement/zero flag).
- Everything else is flat.

## Test plan
- Host write: IDLE, `cpu_T0`=1, `host_req`/`we`=1, addr 0x3, data 0xA5. Expect `ram_we` high for one cycle with `ram_addr`=3, `host_ack` at edge 3, `cpu_hold` low LINGER+1 cycles after the ack.
- Wait for T0: request while `cpu_T0`=0 for 4 cycles. Expect no `cpu_hold` and CPU passthrough intact until the edge after `cpu_T0` rises.
- Burst: 16 back-to-back writes filling 0x0–0xF. Expect `cpu_hold` high continuously and an ack every 2 cycles; readback returns identical data.
- Abandon: drop `host_req` in WAIT_T0. Expect IDLE, no `ram_we` pulse, no ack.
- Reset mid-ACCESS: assert `RESETn`=0. Expect `cpu_hold`=0, `host_ack`=0, `host_rdata`=0x00 immediately.
- With `RAM_ARB_BOOT_HOLD_EN`: after reset `cpu_hold`=1; load 2 bytes, pulse `host_run`. Expect `cpu_hold` to fall on that edge.
